// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_gen_pkg;

  // Immediate format select from main control; 5..7 are illegal.
  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_D  = 3'd1,
    IMM_B  = 3'd2,
    IMM_CB = 3'd3,
    IMM_IM = 3'd4
  } imm_sel_e;

  // Raw field widths per format.
  localparam int unsigned IMM_I_W  = 12;
  localparam int unsigned IMM_D_W  = 9;
  localparam int unsigned IMM_B_W  = 26;
  localparam int unsigned IMM_CB_W = 19;
  localparam int unsigned IMM_IM_W = 16;

  // Branch offsets are word offsets; MOVZ/MOVK hw selects a 16-bit lane.
  localparam int unsigned BR_SHIFT     = 2;
  localparam int unsigned MOV_HW_SHIFT = 16;

  // Occupancy of the output skid buffer.
  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_state_e;

endpackage

// File: rtl/imm_skid_buffer.sv
// Two-entry valid/ready skid buffer. M drives the outputs, S only holds the
// second entry while FULL. ready_o is registered so no combinational path
// runs from ready_i back to the producer.
module imm_skid_buffer
  import imm_gen_pkg::*;
#(
  parameter int unsigned Width = 129
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  buf_state_e       state_q, state_d;
  logic [Width-1:0] m_q, m_d;
  logic [Width-1:0] s_q, s_d;
  logic             rdy_q, rdy_d;
  logic             accept, pop;

  assign accept  = valid_i & rdy_q;
  assign pop     = valid_o & ready_i;
  assign valid_o = (state_q != EMPTY);
  assign ready_o = rdy_q;
  assign data_o  = m_q;

  // Next-state and data steering; flush drops any same-cycle accept or pop.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = data_i;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_d = data_i;
          end else if (accept) begin
            state_d = FULL;
            s_d     = data_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  // State, data and registered ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: rtl/sign_extender.sv
// Sign-extends an N-bit field to W bits.
module sign_extender #(
  parameter int unsigned N = 9,
  parameter int unsigned W = 64
) (
  input  logic [N-1:0] value_i,
  output logic [W-1:0] value_o
);

  assign value_o = {{(W - N){value_i[N-1]}}, value_i};

endmodule

// File: rtl/imm_gen_sequencer.sv
// Decode-stage immediate generator: selects the LEGv8 immediate field,
// extends and shifts it to 64 bits, and queues it in a skid buffer.
module imm_gen_sequencer
  import imm_gen_pkg::*;
#(
  parameter int unsigned TAG_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned PayloadW = 1 + TAG_W + 64;

  logic [63:0]         sext_d, sext_b, sext_cb;
  logic [63:0]         imm;
  logic                err;
  logic [5:0]          mov_shamt;
  logic [PayloadW-1:0] payload_out;
  logic                unused_instr;

  // Opcode bits above the widest field are not part of any immediate.
  assign unused_instr = ^instr[31:26];

  sign_extender #(.N(IMM_D_W), .W(64)) u_sext_d (
    .value_i (instr[20:12]),
    .value_o (sext_d)
  );

  sign_extender #(.N(IMM_CB_W), .W(64)) u_sext_cb (
    .value_i (instr[23:5]),
    .value_o (sext_cb)
  );

  sign_extender #(.N(IMM_B_W), .W(64)) u_sext_b (
    .value_i (instr[25:0]),
    .value_o (sext_b)
  );

  // hw field picks one of four 16-bit lanes.
  assign mov_shamt = 6'(MOV_HW_SHIFT * 32'(instr[22:21]));

  // Format select, extension and shift; illegal selects yield zero with err.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_sel)
      IMM_I:   imm = 64'(instr[21:10]);
      IMM_D:   imm = sext_d;
      IMM_B:   imm = sext_b << BR_SHIFT;
      IMM_CB:  imm = sext_cb << BR_SHIFT;
      IMM_IM:  imm = 64'(instr[20:5]) << mov_shamt;
      default: err = 1'b1;
    endcase
  end

  imm_skid_buffer #(.Width(PayloadW)) u_skid (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  ({err, in_tag, imm}),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (payload_out)
  );

  assign imm_out = payload_out[63:0];
  assign out_tag = payload_out[64 +: TAG_W];
  assign out_err = payload_out[PayloadW-1];

endmodule
